// File: rtl/uart_tx_periph.sv
// rtl/uart_tx_periph.sv - memory-mapped 8N1 UART transmitter with TX FIFO
// Registers: CTRL, BAUDDIV, TXDATA, STATUS selected by addr[3:2]; combinational read.
module uart_tx_periph #(
  parameter int DEFAULT_DIV = 867,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q, state_d;
  logic             en_q, en_d;
  logic [15:0]      div_q, div_d;
  logic             ovf_q, ovf_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       shift_q, shift_d;
  logic [2:0]       idx_q, idx_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             tx_q, tx_d;
  logic [7:0]       mem_q [FIFO_DEPTH];

  logic [1:0] sel;
  logic       we, push_req, push, pop, full, empty, busy, bit_end;
  logic       unused_bits;

  assign sel         = addr[3:2];
  assign we          = cs & wr;
  assign push_req    = we && (sel == 2'd2);
  assign full        = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty       = (count_q == '0);
  assign push        = push_req & ~full;
  assign busy        = (state_q != IDLE);
  assign pop         = (state_q == IDLE) & en_q & ~empty;
  assign bit_end     = (cnt_q >= div_q);
  assign tx          = tx_q;
  assign unused_bits = ^{addr[31:4], addr[1:0], wdata[31:16]};

  always_comb begin
    en_d     = en_q;
    div_d    = div_q;
    ovf_d    = ovf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    tx_d     = tx_q;

    if (we) begin
      case (sel)
        2'd0:    en_d = wdata[0];
        2'd1:    div_d = wdata[15:0];
        2'd3:    if (wdata[3]) ovf_d = 1'b0;
        default: ;
      endcase
    end
    if (push_req && full) ovf_d = 1'b1;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    // Live BAUDDIV compare: a mid-frame write retimes the current bit.
    if (busy) cnt_d = bit_end ? 16'd0 : cnt_q + 16'd1;

    case (state_q)
      IDLE: if (pop) begin
        shift_d = mem_q[rd_ptr_q];
        tx_d    = 1'b0;
        cnt_d   = 16'd0;
        state_d = START;
      end
      START: if (bit_end) begin
        tx_d    = shift_q[0];
        idx_d   = 3'd0;
        state_d = DATA;
      end
      DATA: if (bit_end) begin
        if (idx_q == 3'd7) begin
          tx_d    = 1'b1;
          state_d = STOP;
        end else begin
          shift_d = shift_q >> 1;
          tx_d    = shift_q[1];
          idx_d   = idx_q + 3'd1;
        end
      end
      STOP: if (bit_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      en_q     <= 1'b0;
      div_q    <= 16'(DEFAULT_DIV);
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      shift_q  <= 8'd0;
      idx_q    <= 3'd0;
      cnt_q    <= 16'd0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      div_q    <= div_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      tx_q     <= tx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata[7:0];
  end

  always_comb begin
    rdata = 32'd0;
    if (cs) begin
      case (sel)
        2'd0:    rdata[0]    = en_q;
        2'd1:    rdata[15:0] = div_q;
        2'd3:    rdata[7:0]  = {4'(count_q), ovf_q, busy, empty, full};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_periph.sv
// tb/tb_uart_tx_periph.sv - directed self-checking bench for uart_tx_periph
// Bus reads are sampled 1 ns after driving; tx is sampled 1 ns after each rising edge.
module tb_uart_tx_periph;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        tx;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] rv;
  logic [9:0]  frame55;
  logic [21:0] exp_ab;
  logic        saw_low;

  uart_tx_periph #(.DEFAULT_DIV(867), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .cs(cs), .wr(wr), .addr(addr),
    .wdata(wdata), .rdata(rdata), .tx(tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    #1;
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    cs = 1'b1; wr = 1'b0; addr = a;
    #1;
    d = rdata;
  endtask

  // STATUS = {count[3:0], ovf, busy, empty, full}
  function automatic logic [31:0] status(input int cnt, input bit ovf, input bit bsy,
                                         input bit emp, input bit ful);
    return {24'd0, 4'(cnt), ovf, bsy, emp, ful};
  endfunction

  initial begin
    frame55 = 10'b1_0101_0101_0;
    exp_ab  = 22'b11_0011_1100_0111_0100_0110;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rdata_cs0", rdata, 32'd0);
    bus_rd(32'h4000_0200, rv); check("rst_ctrl", rv, 32'd0);
    bus_rd(32'h4000_0204, rv); check("rst_baud", rv, 32'd867);
    bus_rd(32'h4000_0208, rv); check("rst_txdata", rv, 32'd0);
    bus_rd(32'h4000_020C, rv); check("rst_status", rv, status(0, 0, 0, 1, 0));
    check("rst_tx", {31'd0, tx}, 32'd1);

    // 0x55 frame at BAUDDIV=3
    bus_wr(32'h4000_0204, 32'd3);
    bus_wr(32'h4000_0200, 32'd1);
    bus_wr(32'h4000_0208, 32'h55);
    check("tx_before_pop", {31'd0, tx}, 32'd1);
    cs = 1'b1; wr = 1'b0; addr = 32'h4000_020C;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      check($sformatf("f55_tx_%0d", i), {31'd0, tx}, {31'd0, frame55[i/4]});
      check($sformatf("f55_busy_%0d", i), {31'd0, rdata[2]}, 32'd1);
    end
    @(posedge clk); #1;
    check("f55_done_status", rdata, status(0, 0, 0, 1, 0));
    check("f55_done_tx", {31'd0, tx}, 32'd1);

    // Overflow with EN=0
    bus_wr(32'h4000_0200, 32'd0);
    for (int b = 1; b <= 5; b++) bus_wr(32'h4000_0208, 32'(b));
    bus_rd(32'h4000_020C, rv); check("ovf_status", rv, status(4, 1, 0, 0, 1));
    bus_wr(32'h4000_020C, 32'h8);
    bus_rd(32'h4000_020C, rv); check("ovf_clear", rv, status(4, 0, 0, 0, 1));

    // Push while full in the same cycle as the pop is dropped
    bus_wr(32'h4000_0200, 32'd1);
    bus_wr(32'h4000_0208, 32'h77);
    bus_rd(32'h4000_020C, rv); check("pushpop_status", rv, status(3, 1, 1, 0, 0));
    check("pushpop_tx_start", {31'd0, tx}, 32'd0);

    // Reset asserted mid-DATA of byte 0x01 (bit1 = 0)
    cs = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mid_data_tx", {31'd0, tx}, 32'd0);
    #2 reset = 1'b1;
    #1 check("async_rst_tx", {31'd0, tx}, 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus_rd(32'h4000_020C, rv); check("post_rst_status", rv, status(0, 0, 0, 1, 0));
    bus_rd(32'h4000_0204, rv); check("post_rst_baud", rv, 32'd867);
    cs = 1'b0;
    saw_low = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (tx !== 1'b1) saw_low = 1'b1;
    end
    check("no_residual_frame", {31'd0, saw_low}, 32'd0);

    // Back-to-back 0xA3, 0x3C at BAUDDIV=0
    bus_wr(32'h4000_0204, 32'd0);
    bus_wr(32'h4000_0200, 32'd1);
    bus_wr(32'h4000_0208, 32'hA3);
    bus_wr(32'h4000_0208, 32'h3C);
    check("b2b_tx_0", {31'd0, tx}, {31'd0, exp_ab[0]});
    for (int i = 1; i < 22; i++) begin
      @(posedge clk); #1;
      check($sformatf("b2b_tx_%0d", i), {31'd0, tx}, {31'd0, exp_ab[i]});
    end
    bus_rd(32'h4000_020C, rv); check("b2b_status", rv, status(0, 0, 0, 1, 0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
